// File: rtl/poly_wave_osc.sv
// poly_wave_osc: C_CH-voice DDS oscillator (saw/tri/pulse/alt wave, linear attack-sustain-release envelope, saturating offset-binary mix); ports CK_i/XARST_i/EN_CK_i, per-voice FREQ_i/WAVE_SEL_i/PW_i/GATE_i, shared ENV_RATE_i, outputs MIX_o/WRAP_o/ENV_BUSY_o; `define POLY_WAVE_OSC_NOISE_EN for shared LFSR noise on WAVE_SEL=3, otherwise inverted saw
module poly_wave_osc #(
  parameter int C_CH = 4,
  parameter int C_PHASE_W = 24,
  parameter int C_DAT_W = 12,
  parameter int C_MIX_SHIFT = 2
) (
  input  logic                      CK_i,
  input  logic                      XARST_i,
  input  logic                      EN_CK_i,
  input  logic [C_CH*C_PHASE_W-1:0] FREQ_i,
  input  logic [C_CH*2-1:0]         WAVE_SEL_i,
  input  logic [C_CH*8-1:0]         PW_i,
  input  logic [C_CH-1:0]           GATE_i,
  input  logic [7:0]                ENV_RATE_i,
  output logic [C_DAT_W-1:0]        MIX_o,
  output logic [C_CH-1:0]           WRAP_o,
  output logic [C_CH-1:0]           ENV_BUSY_o
);
  localparam int SW = C_DAT_W + $clog2(C_CH);
  localparam logic [C_DAT_W-1:0] MSB = {1'b1, {(C_DAT_W-1){1'b0}}};
  localparam logic signed [SW-1:0] HI = SW'((1 << (C_DAT_W-1)) - 1);
  localparam logic signed [SW-1:0] LO = ~HI;
  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} env_st_t;
  logic [C_DAT_W-1:0] scaled [C_CH];
`ifdef POLY_WAVE_OSC_NOISE_EN
  logic [15:0] lfsr;
  always_ff @(posedge CK_i or negedge XARST_i)
    if (!XARST_i) lfsr <= 16'hACE1;
    else if (EN_CK_i) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`endif
  for (genvar c = 0; c < C_CH; c++) begin : g_v
    logic [C_PHASE_W-1:0] phase;
    logic [7:0] env, env_n;
    logic [8:0] add, sub;
    logic gate_d, wrap, rise;
    env_st_t st, st_n, st_e;
    logic [1:0] sel;
    logic [C_DAT_W-1:0] t, saw, up, tri_w, sq, alt, wave, sc;
    logic signed [C_DAT_W+8:0] prod;
    assign rise = GATE_i[c] & ~gate_d;
    assign sel = WAVE_SEL_i[c*2 +: 2];
    assign t = phase[C_PHASE_W-1 -: C_DAT_W];
    // XOR with MSB is the same as subtracting H in C_DAT_W-bit two's complement
    assign saw = t ^ MSB;
    assign up = {t[C_DAT_W-2:0], 1'b0} ^ MSB;
    assign tri_w = t[C_DAT_W-1] ? ~up : up;
    assign sq = phase[C_PHASE_W-1 -: 8] < PW_i[c*8 +: 8] ? ~MSB : MSB;
`ifdef POLY_WAVE_OSC_NOISE_EN
    assign alt = lfsr[15 -: C_DAT_W];
`else
    assign alt = ~saw;
`endif
    assign wave = sel == 2'd0 ? saw : sel == 2'd1 ? tri_w : sel == 2'd2 ? sq : alt;
    assign prod = $signed(wave) * $signed({1'b0, env});
    // st_e is the state after gate events; the envelope step of that state applies in the same strobe
    always_comb begin
      st_e = rise ? ATTACK : (!GATE_i[c] && (st == ATTACK || st == SUSTAIN)) ? RELEASE : st;
      add = {1'b0, env} + {1'b0, ENV_RATE_i};
      sub = {1'b0, env} - {1'b0, ENV_RATE_i};
      env_n = env;
      st_n = st_e;
      if (st_e == ATTACK) begin
        env_n = add[8] ? 8'hFF : add[7:0];
        st_n = env_n == 8'hFF ? SUSTAIN : ATTACK;
      end else if (st_e == RELEASE) begin
        env_n = sub[8] ? 8'h00 : sub[7:0];
        st_n = env_n == 8'h00 ? IDLE : RELEASE;
      end
    end
    always_ff @(posedge CK_i or negedge XARST_i)
      if (!XARST_i) st <= IDLE;
      else if (EN_CK_i) st <= st_n;
    always_ff @(posedge CK_i or negedge XARST_i)
      if (!XARST_i) begin
        phase <= '0;
        wrap <= 1'b0;
        gate_d <= 1'b0;
        env <= '0;
        sc <= '0;
      end else if (EN_CK_i) begin
        {wrap, phase} <= rise ? '0 : {1'b0, phase} + {1'b0, FREQ_i[c*C_PHASE_W +: C_PHASE_W]};
        gate_d <= GATE_i[c];
        env <= env_n;
        sc <= C_DAT_W'(prod >>> 8);
      end
    assign scaled[c] = sc;
    assign WRAP_o[c] = wrap;
    assign ENV_BUSY_o[c] = st != IDLE;
  end
  logic signed [SW-1:0] sum, sh;
  logic [C_DAT_W-1:0] clamped;
  always_comb begin
    sum = '0;
    for (int i = 0; i < C_CH; i++) sum = sum + SW'($signed(scaled[i]));
    sh = sum >>> C_MIX_SHIFT;
  end
  assign clamped = sh > HI ? ~MSB : sh < LO ? MSB : sh[C_DAT_W-1:0];
  always_ff @(posedge CK_i or negedge XARST_i)
    if (!XARST_i) MIX_o <= MSB;
    else if (EN_CK_i) MIX_o <= clamped ^ MSB;
endmodule

// File: tb/tb_poly_wave_osc.sv
// tb_poly_wave_osc: scoreboard bench for poly_wave_osc against an arithmetic voice/envelope/mix model
module tb_poly_wave_osc;
  localparam int CH = 4;
  localparam int ATT_M = 1, SUS_M = 2, REL_M = 3;
  logic clk = 1'b0;
  logic XARST_i, EN_CK_i;
  logic [CH*24-1:0] FREQ_i;
  logic [CH*2-1:0] WAVE_SEL_i;
  logic [CH*8-1:0] PW_i;
  logic [CH-1:0] GATE_i;
  logic [7:0] ENV_RATE_i;
  logic [11:0] mix, mix0;
  logic [CH-1:0] wrap, wrap0, busy, busy0;
  int checks = 0, errors = 0;
  typedef struct {int mix; int mix0; int wrap; int busy;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int m_ph[CH], m_env[CH], m_mode[CH];
  bit m_gd[CH];
  bit [CH-1:0] m_wrap;
  int m_lfsr, m_mix, m_mix0;
  int pipe[$];

  always #5 clk = ~clk;

  poly_wave_osc dut (.CK_i(clk), .XARST_i(XARST_i), .EN_CK_i(EN_CK_i), .FREQ_i(FREQ_i),
    .WAVE_SEL_i(WAVE_SEL_i), .PW_i(PW_i), .GATE_i(GATE_i), .ENV_RATE_i(ENV_RATE_i),
    .MIX_o(mix), .WRAP_o(wrap), .ENV_BUSY_o(busy));
  poly_wave_osc #(.C_MIX_SHIFT(0)) dut0 (.CK_i(clk), .XARST_i(XARST_i), .EN_CK_i(EN_CK_i),
    .FREQ_i(FREQ_i), .WAVE_SEL_i(WAVE_SEL_i), .PW_i(PW_i), .GATE_i(GATE_i),
    .ENV_RATE_i(ENV_RATE_i), .MIX_o(mix0), .WRAP_o(wrap0), .ENV_BUSY_o(busy0));

  task automatic chk(input string n, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, act, exp_v, $time);
    end
  endtask

  function automatic int wave_of(input int c);
    int t = m_ph[c] >> 12;
    int sel = int'(WAVE_SEL_i[c*2 +: 2]);
    int saw = t - 2048;
    int nz;
    if (sel == 0) return saw;
    if (sel == 1) return t < 2048 ? 2*t - 2048 : 2047 - 2*(t - 2048);
    if (sel == 2) return (m_ph[c] >> 16) < int'(PW_i[c*8 +: 8]) ? 2047 : -2048;
`ifdef POLY_WAVE_OSC_NOISE_EN
    nz = (m_lfsr >> 4) & 12'hFFF;
    return nz >= 2048 ? nz - 4096 : nz;
`else
    nz = -saw - 1;
    return nz;
`endif
  endfunction

  function automatic int mix_of(input int s, input int sh);
    int v = s >>> sh;
    v = v > 2047 ? 2047 : v < -2048 ? -2048 : v;
    return v + 2048;
  endfunction

  function automatic int busy_of();
    int b = 0;
    for (int c = 0; c < CH; c++) if (m_mode[c] != 0) b |= 1 << c;
    return b;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_ph[c] = 0; m_env[c] = 0; m_mode[c] = 0; m_gd[c] = 0;
    end
    m_wrap = '0;
    m_lfsr = 16'hACE1;
    m_mix = 2048;
    m_mix0 = 2048;
    pipe.delete();
    pipe.push_back(0);
  endtask

  task automatic model_step();
    int sum = 0;
    int nx, rate;
    bit g, rise;
    rate = int'(ENV_RATE_i);
    for (int c = 0; c < CH; c++) sum += (wave_of(c) * m_env[c]) >>> 8;
    pipe.push_back(sum);
    sum = pipe.pop_front();
    m_mix = mix_of(sum, 2);
    m_mix0 = mix_of(sum, 0);
    m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1)) & 16'hFFFF;
    for (int c = 0; c < CH; c++) begin
      g = GATE_i[c];
      rise = g && !m_gd[c];
      m_gd[c] = g;
      nx = m_ph[c] + int'(FREQ_i[c*24 +: 24]);
      m_wrap[c] = !rise && nx >= (1 << 24);
      m_ph[c] = rise ? 0 : nx % (1 << 24);
      if (rise) m_mode[c] = ATT_M;
      else if (!g && (m_mode[c] == ATT_M || m_mode[c] == SUS_M)) m_mode[c] = REL_M;
      if (m_mode[c] == ATT_M) begin
        m_env[c] = m_env[c] + rate > 255 ? 255 : m_env[c] + rate;
        if (m_env[c] == 255) m_mode[c] = SUS_M;
      end else if (m_mode[c] == REL_M) begin
        m_env[c] = m_env[c] - rate < 0 ? 0 : m_env[c] - rate;
        if (m_env[c] == 0) m_mode[c] = 0;
      end
    end
  endtask

  task automatic step(input bit en);
    exp_t e;
    EN_CK_i = en;
    if (!XARST_i) model_reset();
    else if (en) model_step();
    e.mix = m_mix; e.mix0 = m_mix0; e.wrap = int'(m_wrap); e.busy = busy_of();
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  task automatic randomize_inputs();
    if ($urandom_range(0, 7) == 0) GATE_i = CH'($urandom);
    if ($urandom_range(0, 15) == 0)
      for (int c = 0; c < CH; c++) FREQ_i[c*24 +: 24] = 24'($urandom);
    if ($urandom_range(0, 15) == 0) WAVE_SEL_i = 8'($urandom);
    if ($urandom_range(0, 15) == 0) PW_i = 32'($urandom);
    if ($urandom_range(0, 15) == 0) ENV_RATE_i = $urandom_range(0, 3) == 0 ? 8'd0 : 8'($urandom_range(1, 64));
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("mix", int'(mix), mon_e.mix);
      chk("mix_shift0", int'(mix0), mon_e.mix0);
      chk("wrap", int'(wrap), mon_e.wrap);
      chk("wrap_shift0", int'(wrap0), mon_e.wrap);
      chk("busy", int'(busy), mon_e.busy);
      chk("busy_shift0", int'(busy0), mon_e.busy);
    end
  end

  initial begin
    XARST_i = 1'b1; EN_CK_i = 1'b1; FREQ_i = '0; WAVE_SEL_i = '0; PW_i = '0;
    GATE_i = '0; ENV_RATE_i = '0;
    model_reset();
    #1 XARST_i = 1'b0;
    @(negedge clk);
    run(100);
    XARST_i = 1'b1;
    FREQ_i[23:0] = 24'h100000; GATE_i = 4'b0001; ENV_RATE_i = 8'd255;
    run(40);
    WAVE_SEL_i = 8'b10; PW_i[7:0] = 8'h80;
    run(40);
    GATE_i = '0;
    run(2);
    WAVE_SEL_i = 8'hAA; PW_i = {4{8'h80}}; FREQ_i = {4{24'h100000}}; GATE_i = 4'hF;
    run(40);
    GATE_i = '0; ENV_RATE_i = 8'd16; WAVE_SEL_i = 8'h00;
    run(20);
    GATE_i = 4'b0001;
    run(16);
    GATE_i = 4'b0000;
    run(8);
    GATE_i = 4'b0001;
    run(20);
    for (int k = 0; k < 600; k++) begin
      randomize_inputs();
      step($urandom_range(0, 3) != 0);
    end
    GATE_i = '0; ENV_RATE_i = 8'd255;
    run(2);
    WAVE_SEL_i = 8'hE4; GATE_i = 4'hF;
    for (int c = 0; c < CH; c++) FREQ_i[c*24 +: 24] = 24'($urandom_range(1, 24'h3FFFF));
    run(10);
    #2 XARST_i = 1'b0;
    #1;
    chk("async_rst_mix", int'(mix), 2048);
    chk("async_rst_mix_shift0", int'(mix0), 2048);
    chk("async_rst_wrap", int'(wrap), 0);
    chk("async_rst_busy", int'(busy), 0);
    step(1'b1);
    run(3);
    XARST_i = 1'b1; WAVE_SEL_i = 8'hFF;
    run(30);
    for (int k = 0; k < 200; k++) begin
      randomize_inputs();
      step($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
